seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised, runtime-programmable serial bit-pattern detector. It is the successor to the fixed 4-bit Moore detector. It sits on a serial input stream qualified by a valid strobe and pulses `detect_out` when the last `cfg_len` accepted bits equal the programmed pattern. Overlapping or non-overlapping matching is selected at run time, and a saturating counter records the number of detections.

## Interface
Parameters:
- `MAX_LEN`, default 8: maximum pattern length in bits, ≥ 2.
- `LEN_W`, default `$clog2(MAX_LEN+1)`: width of `cfg_len`.
- `CNT_W`, default 8: width of `match_count`.
- `DEF_PATTERN`, default `'b1011`: pattern loaded at reset, right-aligned.
- `DEF_LEN`, default 4: length loaded at reset.
- `DEF_OVERLAP`, default 0: mode loaded at reset. 0 selects non-overlapping.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `seq_in`, in, 1: serial data bit.
- `seq_valid`, in, 1: `seq_in` is accepted only on edges where this is high.
- `cfg_load`, in, 1: latch the `cfg_*` inputs on this edge.
- `cfg_pattern`, in, `MAX_LEN`: pattern, right-aligned. Bit `len-1` is the first bit received, bit 0 the last.
- `cfg_len`, in, `LEN_W`: pattern length.
- `cfg_overlap`, in, 1: 1 selects overlapping, 0 selects non-overlapping.
- `detect_out`, out, 1: registered one-cycle detection pulse.
- `match_count`, out, `CNT_W`: saturating count of detections.

## Operation
- **Active configuration.** The registers `pat`, `len` and `ovl` hold the active configuration. Reset loads `DEF_*` into them. `cfg_load` replaces them with the `cfg_*` inputs.
- **Length clamp.** `cfg_len` of 0 is stored as 1. `cfg_len` greater than `MAX_LEN` is stored as `MAX_LEN`.
- **History.** `hist[MAX_LEN-1:0]` shifts left on each accepted bit, with the new bit entering at bit 0.
- **Fill count.** `fill`, saturating at `MAX_LEN`, counts accepted bits that are eligible for a match.
- **Match condition.** An accepted bit completes a match when all of the following hold:
  - the post-shift `fill` is ≥ `len`;
  - the post-shift `hist[len-1:0]` equals `pat[len-1:0]`;
  - `cfg_load` is low on that edge.
- **Stage 1.** `match_q` is set on the edge that accepts the completing bit and is 0 otherwise.
- **Stage 2.** `detect_out` is set from `match_q` on the next edge. On that same edge, `match_count` increments, saturating at all ones.
- **Non-overlapping mode (`ovl`=0).** When a match is registered, `fill` is set to 0 on the same edge. The bits of that match can therefore never contribute to a later match.
- **Overlapping mode (`ovl`=1).** `fill` is unaffected by a match. Each accepted bit may complete a match.
- **Configuration load edge.** On a `cfg_load` edge:
  - `hist`, `fill`, `match_q` and `match_count` clear to 0;
  - any `seq_valid` on that edge is ignored;
  - `detect_out` still emits an already-pending `match_q`, but does not count it.
- **Idle edges.** On edges with `seq_valid` low, `hist` and `fill` hold and `match_q` goes to 0.

## Timing
- **Reset values** (asynchronous, immediate):
  - `detect_out`=0, `match_count`=0, `match_q`=0;
  - `hist`=0, `fill`=0;
  - `pat`/`len`/`ovl` = `DEF_PATTERN`/`DEF_LEN`/`DEF_OVERLAP`.
- **Latency.** The completing bit is accepted at edge N. `match_q` is high after edge N. `detect_out` is high for exactly the cycle after edge N+1.
- **Pulse width.** `detect_out` is never high for more than one cycle per match.
- **Back-to-back matches.** In overlapping mode with `len`=1, consecutive matching bits produce consecutive `detect_out` cycles, and the count increments every cycle.
- **Reset mid-operation.** Any pending `match_q` is discarded. No pulse appears after reset deasserts.
- **Saturation.** `match_count` at `2^CNT_W-1` holds while `detect_out` continues to pulse.
- **Pattern bits above `len-1`.** These bits of `pat` are ignored.
- **State encoding.** No one-hot or enumerated state is required. The history and fill counter form the state machine.

## Test plan
1. **Default configuration, non-overlapping.** After reset, send 1,0,1,1 with `seq_valid`=1 on every edge. Require `detect_out` high for one cycle two edges after the final 1, and `match_count`=1.
2. **Overlap versus non-overlap.** Load pattern 1011, `len`=4. Send 1,0,1,1,0,1,1.
   - `cfg_overlap`=1: require 2 pulses, 3 cycles apart, and `match_count`=2.
   - `cfg_overlap`=0: require 1 pulse and `match_count`=1.
3. **Valid gaps.** With the default configuration, send 1,0,1,1 with `seq_valid` low for 3 cycles between each bit. Require exactly one pulse, two edges after the edge accepting the last bit. Require no pulse during the gaps.
4. **Reconfiguration.** Load `len`=8, pattern 0xA5, overlap=1. Send 1,0,1,0,0,1,0,1 then 1,0,1,0,0,1,0,1. Require 2 detections.
   - Then assert `cfg_load` after sending only 7 bits of a third copy. Require `match_count`=0 and no detection from those partial bits.
   - Also load `cfg_len`=0 and confirm it behaves as `len`=1.
5. **Saturation.** With `CNT_W`=3, load pattern 1, `len`=1, overlap=1, and send 10 consecutive 1s. Require 10 `detect_out` pulses and `match_count` holding at 7.
6. **Reset mid-match.** Assert `reset` for 1 cycle in the cycle after the final bit of a 1011 match has been accepted. Require `detect_out`=0 throughout and `match_count`=0. Require `pat`/`len` to revert to the defaults, verified by detecting 1011 again.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Runtime-programmable serial bit-pattern detector. Each accepted bit shifts
// into a history register. A match is flagged when the last `len` eligible
// bits equal the programmed pattern. The match flag is registered (stage 1)
// and then emitted as a one-cycle pulse (stage 2). A saturating counter
// records the number of detections.
// The history register and the fill counter together act as the state
// machine, so no enumerated state register is needed.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b1011,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               seq_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               detect_out,
  output logic [CNT_W-1:0]   match_count
);

  // The fill counter and the stored length only ever need to reach MAX_LEN.
  localparam int FILL_W = $clog2(MAX_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);
  localparam int DEF_LEN_I = (DEF_LEN < 1) ? 1 : ((DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN);
  localparam logic [FILL_W-1:0] DEF_LEN_C = FILL_W'(DEF_LEN_I);

  // Active configuration.
  logic [MAX_LEN-1:0] r_pat;
  logic [FILL_W-1:0]  r_len;
  logic               r_ovl;

  // Datapath and pipeline state.
  logic [MAX_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_match_q;
  logic               r_detect;
  logic [CNT_W-1:0]   r_count;

  // Combinational helpers.
  logic [FILL_W-1:0]  w_cfg_len;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [FILL_W-1:0]  w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_accept;
  logic               w_match;

  // Clamp the requested length into 1..MAX_LEN before it is stored.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    w_cfg_len = FILL_W'(cfg_len);
    if (cfg_len == '0) begin
      w_cfg_len = FILL_W'(1);
    end else if (int'(cfg_len) > MAX_LEN) begin
      w_cfg_len = FILL_MAX;
    end
  end

  // A configuration load overrides any bit offered on the same edge.
  assign w_accept    = seq_valid & ~cfg_load;
  assign w_hist_next = {r_hist[MAX_LEN-2:0], seq_in};
  assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
  // Low `len` bits set. A shift by MAX_LEN yields all ones, so the full
  // length needs no special case.
  assign w_mask      = ~({MAX_LEN{1'b1}} << r_len);
  assign w_match     = w_accept
                     & (w_fill_next >= r_len)
                     & (((w_hist_next ^ r_pat) & w_mask) == '0);

  // Active configuration register: defaults at reset, replaced on cfg_load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat <= DEF_PATTERN;
      r_len <= DEF_LEN_C;
      r_ovl <= DEF_OVERLAP;
    end else if (cfg_load) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the pre-edge values regardless of statement order.
      r_pat <= cfg_pattern;
      r_len <= w_cfg_len;
      r_ovl <= cfg_overlap;
    end
  end

  // History shift, fill tracking and stage-1 match flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_match_q <= 1'b0;
    end else if (cfg_load) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= w_match;
      if (w_accept) begin
        r_hist <= w_hist_next;
        // In non-overlapping mode a match consumes its bits.
        r_fill <= (w_match && !r_ovl) ? '0 : w_fill_next;
      end
    end
  end

  // Stage 2: emit the pulse and count it. A load edge still lets a pending
  // match out, but the counter clears instead of counting that match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_detect <= 1'b0;
      r_count  <= '0;
    end else begin
      r_detect <= r_match_q;
      if (cfg_load) begin
        r_count <= '0;
      end else if (r_match_q && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign detect_out  = r_detect;
  assign match_count = r_count;

endmodule
